// File: rtl/csv_formatter.sv
// Serializes one sensor frame into an ASCII CSV line, one character per
// valid/ready handshake, in the format "ax1,ay1,az1;ax2,ay2,az2,jx,jy,btn\n".
module csv_formatter #(
  parameter int AW = 16,
  parameter int JW = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic [AW-1:0] ax1,
  input  logic [AW-1:0] ay1,
  input  logic [AW-1:0] az1,
  input  logic [AW-1:0] ax2,
  input  logic [AW-1:0] ay2,
  input  logic [AW-1:0] az2,
  input  logic [JW-1:0] jx,
  input  logic [JW-1:0] jy,
  input  logic          btn,
  input  logic          frame_val,
  output logic          frame_rdy,
  output logic [7:0]    char_out,
  output logic          char_val,
  input  logic          char_rdy,
  output logic          busy,
  output logic          line_done
);

  typedef enum logic [1:0] {IDLE, DIGIT, SEP} state_t;

  state_t      state_reg;
  logic [3:0]  field_reg;
  logic [15:0] rem_reg;
  logic [2:0]  pidx_reg;
  logic [15:0] vals_reg [9];
  logic [15:0] frame_in [9];

  assign frame_in[0] = 16'(ax1);
  assign frame_in[1] = 16'(ay1);
  assign frame_in[2] = 16'(az1);
  assign frame_in[3] = 16'(ax2);
  assign frame_in[4] = 16'(ay2);
  assign frame_in[5] = 16'(az2);
  assign frame_in[6] = 16'(jx);
  assign frame_in[7] = 16'(jy);
  assign frame_in[8] = 16'(btn);

  function automatic logic [16:0] pow_of(input logic [2:0] p);
    case (p)
      3'd4:    return 17'd10000;
      3'd3:    return 17'd1000;
      3'd2:    return 17'd100;
      3'd1:    return 17'd10;
      default: return 17'd1;
    endcase
  endfunction

  function automatic logic [2:0] start_pow(input logic [15:0] v);
    if (v >= 16'd10000)     return 3'd4;
    else if (v >= 16'd1000) return 3'd3;
    else if (v >= 16'd100)  return 3'd2;
    else if (v >= 16'd10)   return 3'd1;
    else                    return 3'd0;
  endfunction

  // Largest d in 0..9 with d*pow <= r.
  function automatic logic [3:0] digit_of(input logic [15:0] r, input logic [2:0] p);
    logic [16:0] pw;
    logic [3:0]  d;
    pw = pow_of(p);
    d  = 4'd0;
    for (int k = 1; k <= 9; k++) begin
      if (17'(k) * pw <= {1'b0, r}) d = 4'(k);
    end
    return d;
  endfunction

  logic [3:0]  cur_digit;
  logic [15:0] step_rem;
  logic [2:0]  step_pidx;
  logic [3:0]  step_digit;
  logic [3:0]  next_field;
  logic [15:0] load_val;
  logic [2:0]  load_pidx;
  logic [3:0]  load_digit;
  logic [7:0]  sep_char;

  always_comb begin
    cur_digit  = digit_of(rem_reg, pidx_reg);
    // d*pow never exceeds rem, so the product fits in 16 bits.
    step_rem   = rem_reg - 16'(17'(cur_digit) * pow_of(pidx_reg));
    step_pidx  = pidx_reg - 3'd1;
    step_digit = digit_of(step_rem, step_pidx);
    next_field = (state_reg == IDLE || field_reg == 4'd8) ? 4'd0 : field_reg + 4'd1;
    load_val   = (state_reg == IDLE) ? frame_in[0] : vals_reg[next_field];
    load_pidx  = start_pow(load_val);
    load_digit = digit_of(load_val, load_pidx);
    if (field_reg == 4'd8)      sep_char = 8'h0A;
    else if (field_reg == 4'd2) sep_char = 8'h3B;
    else                        sep_char = 8'h2C;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      field_reg <= 4'd0;
      rem_reg   <= 16'd0;
      pidx_reg  <= 3'd0;
      char_out  <= 8'h00;
      char_val  <= 1'b0;
      busy      <= 1'b0;
      line_done <= 1'b0;
      frame_rdy <= 1'b1;
    end else begin
      line_done <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (frame_val) begin
            for (int i = 0; i < 9; i++) vals_reg[i] <= frame_in[i];
            field_reg <= 4'd0;
            rem_reg   <= load_val;
            pidx_reg  <= load_pidx;
            char_out  <= 8'h30 + {4'h0, load_digit};
            char_val  <= 1'b1;
            busy      <= 1'b1;
            frame_rdy <= 1'b0;
            state_reg <= DIGIT;
          end
        end
        DIGIT: begin
          if (char_rdy) begin
            if (pidx_reg != 3'd0) begin
              rem_reg  <= step_rem;
              pidx_reg <= step_pidx;
              char_out <= 8'h30 + {4'h0, step_digit};
            end else begin
              char_out  <= sep_char;
              state_reg <= SEP;
            end
          end
        end
        SEP: begin
          if (char_rdy) begin
            if (field_reg != 4'd8) begin
              field_reg <= next_field;
              rem_reg   <= load_val;
              pidx_reg  <= load_pidx;
              char_out  <= 8'h30 + {4'h0, load_digit};
              state_reg <= DIGIT;
            end else begin
              field_reg <= 4'd0;
              char_out  <= 8'h00;
              char_val  <= 1'b0;
              busy      <= 1'b0;
              frame_rdy <= 1'b1;
              line_done <= 1'b1;
              state_reg <= IDLE;
            end
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_csv_formatter.sv
// Directed bench for csv_formatter: golden lines, backpressure, back-to-back,
// loopback parsing and mid-line reset.
module tb_csv_formatter;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] ax1, ay1, az1, ax2, ay2, az2;
  logic [11:0] jx, jy;
  logic        btn, frame_val, frame_rdy, char_val, char_rdy, busy, line_done;
  logic [7:0]  char_out;

  int  vectors = 0;
  int  miscompares = 0;
  byte rx_q[$];
  int  first_cyc, last_cyc, stab_err, valid_err, busy_err;
  bit  got_nl;
  int  fv[9];

  always #5 clk = ~clk;

  csv_formatter dut (
    .clk(clk), .rst_n(rst_n),
    .ax1(ax1), .ay1(ay1), .az1(az1), .ax2(ax2), .ay2(ay2), .az2(az2),
    .jx(jx), .jy(jy), .btn(btn),
    .frame_val(frame_val), .frame_rdy(frame_rdy),
    .char_out(char_out), .char_val(char_val), .char_rdy(char_rdy),
    .busy(busy), .line_done(line_done)
  );

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic set_frame(input int a0, a1, a2, a3, a4, a5, a6, a7, a8);
    fv[0] = a0; fv[1] = a1; fv[2] = a2; fv[3] = a3; fv[4] = a4;
    fv[5] = a5; fv[6] = a6; fv[7] = a7; fv[8] = a8;
  endtask

  task automatic drive_values();
    ax1 = 16'(fv[0]); ay1 = 16'(fv[1]); az1 = 16'(fv[2]);
    ax2 = 16'(fv[3]); ay2 = 16'(fv[4]); az2 = 16'(fv[5]);
    jx  = 12'(fv[6]); jy  = 12'(fv[7]); btn = fv[8][0];
  endtask

  // Presents the frame just before the accepting edge.
  task automatic launch();
    drive_values();
    @(negedge clk);
    char_rdy  = 1'b1;
    frame_val = 1'b1;
  endtask

  // Accepts characters until '\n'; cycle 1 is the first cycle after acceptance.
  task automatic collect(input bit stall, input bit drop_fv);
    int  cyc;
    bit  pv, pr, rdy;
    byte pc;
    rx_q.delete();
    stab_err = 0; valid_err = 0; busy_err = 0; got_nl = 0; first_cyc = -1;
    cyc = 0; pv = 0; pr = 0; pc = 0;
    while (!got_nl && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (drop_fv) frame_val = 1'b0;
      if (pv && !pr && (char_val !== 1'b1 || char_out !== pc)) stab_err++;
      if (char_val !== 1'b1) valid_err++;
      if (busy !== 1'b1 || frame_rdy !== 1'b0) busy_err++;
      rdy = stall ? ($urandom_range(0, 99) >= 45) : 1'b1;
      char_rdy = rdy;
      if (char_val === 1'b1) begin
        if (first_cyc < 0) first_cyc = cyc;
        if (rdy) begin
          rx_q.push_back(char_out);
          if (char_out == 8'h0A) got_nl = 1;
        end
      end
      pv = (char_val === 1'b1);
      pr = rdy;
      pc = char_out;
    end
    last_cyc = cyc;
  endtask

  function automatic string show();
    string g = "";
    foreach (rx_q[i]) g = (rx_q[i] == 8'h0A) ? {g, "\\n"} : $sformatf("%s%c", g, rx_q[i]);
    return g;
  endfunction

  function automatic bit line_matches(input string exp);
    if (rx_q.size() != exp.len()) return 0;
    foreach (rx_q[i]) if (rx_q[i] != exp[i]) return 0;
    return 1;
  endfunction

  task automatic test_reset();
    rst_n = 1'b0; frame_val = 1'b0; char_rdy = 1'b0;
    set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
    drive_values();
    repeat (3) @(negedge clk);
    vectors++; if (char_val !== 1'b0) begin miscompares++; $display("FAIL reset_char_val got %b want 0", char_val); end
    vectors++; if (char_out !== 8'h00) begin miscompares++; $display("FAIL reset_char_out got %h want 00", char_out); end
    vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy got %b want 0", busy); end
    vectors++; if (line_done !== 1'b0) begin miscompares++; $display("FAIL reset_line_done got %b want 0", line_done); end
    vectors++; if (frame_rdy !== 1'b1) begin miscompares++; $display("FAIL reset_frame_rdy got %b want 1", frame_rdy); end
    rst_n = 1'b1;
    @(negedge clk);
    $display("reset: outputs checked");
  endtask

  task automatic test_mixed();
    string exp = "1234,0,65535;7,10,100,4095,2048,1\n";
    set_frame(1234, 0, 65535, 7, 10, 100, 4095, 2048, 1);
    launch();
    collect(0, 1);
    $display("mixed: %s (%0d chars, cycles %0d..%0d)", show(), rx_q.size(), first_cyc, last_cyc);
    vectors++; if (!got_nl || !line_matches(exp)) begin miscompares++; $display("FAIL mixed_line got \"%s\" want \"1234,0,65535;7,10,100,4095,2048,1\\n\"", show()); end
    vectors++; if (first_cyc != 1 || last_cyc != 34) begin miscompares++; $display("FAIL mixed_timing got %0d..%0d want 1..34", first_cyc, last_cyc); end
    vectors++; if (valid_err != 0 || busy_err != 0) begin miscompares++; $display("FAIL mixed_flags got valid_err=%0d busy_err=%0d want 0/0", valid_err, busy_err); end
    @(negedge clk);
    vectors++; if (line_done !== 1'b1 || frame_rdy !== 1'b1 || busy !== 1'b0) begin miscompares++; $display("FAIL mixed_done got ld=%b rdy=%b busy=%b want 1/1/0", line_done, frame_rdy, busy); end
    @(negedge clk);
    vectors++; if (line_done !== 1'b0) begin miscompares++; $display("FAIL mixed_done_pulse got %b want 0", line_done); end
  endtask

  task automatic test_zeros();
    string exp = "0,0,0;0,0,0,0,0,0\n";
    set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0);
    launch();
    collect(0, 1);
    $display("zeros: %s (%0d chars)", show(), rx_q.size());
    vectors++; if (!got_nl || !line_matches(exp) || last_cyc != 18) begin miscompares++; $display("FAIL zeros_line got \"%s\" len %0d want \"0,0,0;0,0,0,0,0,0\\n\" len 18", show(), rx_q.size()); end
    @(negedge clk);
    vectors++; if (line_done !== 1'b1) begin miscompares++; $display("FAIL zeros_done got %b want 1", line_done); end
  endtask

  task automatic test_boundaries();
    string exp = "9,10,99;100,9999,10000,1000,999,0\n";
    set_frame(9, 10, 99, 100, 9999, 10000, 1000, 999, 0);
    launch();
    collect(0, 1);
    $display("bounds: %s (%0d chars)", show(), rx_q.size());
    vectors++; if (!got_nl || !line_matches(exp)) begin miscompares++; $display("FAIL bounds_line got \"%s\" want \"9,10,99;100,9999,10000,1000,999,0\\n\"", show()); end
    @(negedge clk);
  endtask

  task automatic test_backpressure();
    string exp = "9,10,99;100,9999,10000,1000,999,0\n";
    set_frame(9, 10, 99, 100, 9999, 10000, 1000, 999, 0);
    launch();
    collect(1, 1);
    $display("stall: %s (%0d chars in %0d cycles)", show(), rx_q.size(), last_cyc);
    vectors++; if (!got_nl || !line_matches(exp)) begin miscompares++; $display("FAIL stall_line got \"%s\" want \"9,10,99;100,9999,10000,1000,999,0\\n\"", show()); end
    vectors++; if (stab_err != 0 || valid_err != 0) begin miscompares++; $display("FAIL stall_hold got stab_err=%0d valid_err=%0d want 0/0", stab_err, valid_err); end
    @(negedge clk);
    vectors++; if (line_done !== 1'b1) begin miscompares++; $display("FAIL stall_done got %b want 1", line_done); end
  endtask

  task automatic test_back_to_back();
    string exp1 = "1234,0,65535;7,10,100,4095,2048,1\n";
    string exp2 = "0,0,0;0,0,0,0,0,0\n";
    set_frame(1234, 0, 65535, 7, 10, 100, 4095, 2048, 1);
    launch();
    fork
      collect(0, 0);
      begin
        @(negedge clk);
        set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0); drive_values();
        repeat (10) @(negedge clk);
        set_frame(5, 5, 5, 5, 5, 5, 5, 5, 1); drive_values();
        @(negedge clk);
        set_frame(0, 0, 0, 0, 0, 0, 0, 0, 0); drive_values();
      end
    join
    $display("b2b line1: %s (%0d chars)", show(), rx_q.size());
    vectors++; if (!got_nl || !line_matches(exp1) || last_cyc != 34) begin miscompares++; $display("FAIL b2b_line1 got \"%s\" end %0d want mixed line end 34", show(), last_cyc); end
    @(negedge clk);
    vectors++; if (line_done !== 1'b1 || frame_rdy !== 1'b1) begin miscompares++; $display("FAIL b2b_gap got ld=%b rdy=%b want 1/1", line_done, frame_rdy); end
    collect(0, 1);
    $display("b2b line2: %s (%0d chars, first cycle %0d)", show(), rx_q.size(), first_cyc);
    vectors++; if (!got_nl || !line_matches(exp2) || first_cyc != 1) begin miscompares++; $display("FAIL b2b_line2 got \"%s\" first %0d want zeros line first 1", show(), first_cyc); end
    @(negedge clk);
    repeat (3) @(negedge clk);
    vectors++; if (char_val !== 1'b0 || busy !== 1'b0) begin miscompares++; $display("FAIL b2b_no_third got val=%b busy=%b want 0/0", char_val, busy); end
  endtask

  task automatic test_loopback();
    int pf[9];
    int nf, acc, semi_at;
    bit ok;
    set_frame(65535, 65535, 65535, 65535, 65535, 65535, 4095, 4095, 1);
    launch();
    collect(1, 1);
    nf = 0; acc = 0; semi_at = -1;
    foreach (rx_q[i]) begin
      if (rx_q[i] >= 8'h30 && rx_q[i] <= 8'h39) acc = acc * 10 + int'(rx_q[i] - 8'h30);
      else begin
        if (nf < 9) pf[nf] = acc;
        if (rx_q[i] == 8'h3B) semi_at = nf;
        nf++;
        acc = 0;
      end
    end
    $display("loopback: %s (%0d chars, %0d fields)", show(), rx_q.size(), nf);
    vectors++; if (!got_nl || rx_q.size() != 48) begin miscompares++; $display("FAIL loop_len got %0d want 48", rx_q.size()); end
    vectors++; if (nf != 9 || semi_at != 2) begin miscompares++; $display("FAIL loop_shape got fields=%0d semi_at=%0d want 9/2", nf, semi_at); end
    ok = (nf == 9);
    for (int i = 0; i < 9; i++) if (ok && pf[i] != fv[i]) ok = 0;
    vectors++; if (!ok) begin miscompares++; $display("FAIL loop_fields got f0=%0d f6=%0d f8=%0d want %0d %0d %0d", pf[0], pf[6], pf[8], fv[0], fv[6], fv[8]); end
    @(negedge clk);
  endtask

  task automatic test_mid_reset();
    string exp = "9,10,99;100,9999,10000,1000,999,0\n";
    set_frame(1234, 0, 65535, 7, 10, 100, 4095, 2048, 1);
    launch();
    @(negedge clk);
    frame_val = 1'b0;
    repeat (4) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    vectors++; if (char_val !== 1'b0 || char_out !== 8'h00) begin miscompares++; $display("FAIL midrst_char got val=%b out=%h want 0/00", char_val, char_out); end
    vectors++; if (busy !== 1'b0 || line_done !== 1'b0 || frame_rdy !== 1'b1) begin miscompares++; $display("FAIL midrst_flags got busy=%b ld=%b rdy=%b want 0/0/1", busy, line_done, frame_rdy); end
    repeat (2) @(negedge clk);
    vectors++; if (char_val !== 1'b0) begin miscompares++; $display("FAIL midrst_idle got val=%b want 0", char_val); end
    set_frame(9, 10, 99, 100, 9999, 10000, 1000, 999, 0);
    launch();
    collect(0, 1);
    $display("after reset: %s (%0d chars)", show(), rx_q.size());
    vectors++; if (!got_nl || !line_matches(exp) || first_cyc != 1) begin miscompares++; $display("FAIL midrst_next got \"%s\" first %0d want bounds line first 1", show(), first_cyc); end
    @(negedge clk);
  endtask

  initial begin
    test_reset();
    test_mixed();
    test_zeros();
    test_boundaries();
    test_backpressure();
    test_back_to_back();
    test_loopback();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
